// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmit path among NUM_REQ byte-stream requesters. This
//   block is the only master of the UART register port. It polls STATUS before
//   every byte and writes TX only after it has seen the TX FIFO not full.
//   Requesters are served round-robin. A packet lock (req_last low) keeps the
//   bytes of one message contiguous. A lock whose owner goes idle is released
//   after LOCK_TIMEOUT idle cycles (0 = never released).
//
// Ports
//   i_clk              system clock
//   i_rst_n            asynchronous reset, active low
//   i_req_valid        per-requester byte available
//   i_req_data         byte of requester i at [8i+7:8i]
//   i_req_last         byte of requester i ends its packet
//   o_req_ready        byte of requester i consumed this cycle (one-hot)
//   o_uart_address     UART register address
//   o_uart_write_data  UART write data (byte zero-extended)
//   o_uart_we          UART write strobe
//   o_uart_re          UART read strobe
//   i_uart_read_data   UART read data, combinational on o_uart_address
//   o_grant_id         current owner index
//   o_locked           packet lock held by o_grant_id
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int         NUM_REQ      = 2,
   parameter int         LOCK_TIMEOUT = 1024,
   parameter logic [7:0] STATUS_ADDR  = 8'h08,
   parameter logic [7:0] TX_ADDR      = 8'h0C
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst_n,
   input  logic [NUM_REQ-1:0]                         i_req_valid,
   input  logic [8*NUM_REQ-1:0]                       i_req_data,
   input  logic [NUM_REQ-1:0]                         i_req_last,
   output logic [NUM_REQ-1:0]                         o_req_ready,
   output logic [7:0]                                 o_uart_address,
   output logic [31:0]                                o_uart_write_data,
   output logic                                       o_uart_we,
   output logic                                       o_uart_re,
   input  logic [31:0]                                i_uart_read_data,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grant_id,
   output logic                                       o_locked
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POLL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t               r_state;
   logic [GW-1:0]        r_rr_ptr;
   logic [GW-1:0]        r_grant;
   logic                 r_locked;
   logic [TW-1:0]        r_tcnt;
   logic [NUM_REQ-1:0]   r_ready;
   logic [7:0]           r_addr;
   logic [31:0]          r_wdata;
   logic                 r_we;
   logic                 r_re;

   logic                 w_found;
   logic [GW-1:0]        w_winner;
   logic                 w_fifo_full;
   logic                 w_unused;

   assign w_fifo_full = i_uart_read_data[1];
   assign w_unused    = ^{i_uart_read_data[31:2], i_uart_read_data[0]};

   // Round-robin search starting at r_rr_ptr. Walking the offsets from the
   // far end down lets the closest valid requester overwrite the others.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(r_rr_ptr) + i) % NUM_REQ;
         if (i_req_valid[idx]) begin
            w_found  = 1'b1;
            w_winner = GW'(idx);
         end
      end
   end

   // All bus outputs are registered alongside the state, so the UART port is
   // a pure function of state/owner and drops to zero on reset immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_locked <= 1'b0;
         r_tcnt   <= '0;
         r_ready  <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_re     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_locked) begin
                  if (i_req_valid[r_grant]) begin
                     r_state <= S_POLL;
                     r_addr  <= STATUS_ADDR;
                     r_re    <= 1'b1;
                  end else if (LOCK_TIMEOUT != 0) begin
                     // Owner went quiet mid-packet: give the bus back eventually.
                     if (r_tcnt == TW'(LOCK_TIMEOUT - 1)) begin
                        r_locked <= 1'b0;
                        r_tcnt   <= '0;
                     end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                     end
                  end
               end else if (w_found) begin
                  r_grant <= w_winner;
                  r_state <= S_POLL;
                  r_addr  <= STATUS_ADDR;
                  r_re    <= 1'b1;
               end
            end

            S_POLL: begin
               if (w_fifo_full) begin
                  // Keep reading STATUS until space appears.
                  r_state <= S_POLL;
               end else if (i_req_valid[r_grant]) begin
                  r_state <= S_WRITE;
                  r_re    <= 1'b0;
                  r_we    <= 1'b1;
                  r_addr  <= TX_ADDR;
                  r_wdata <= {24'd0, i_req_data[8*r_grant +: 8]};
                  r_ready <= NUM_REQ'(1) << r_grant;
               end else begin
                  // Requester withdrew before its byte was written.
                  r_state <= S_IDLE;
                  r_re    <= 1'b0;
                  r_addr  <= '0;
               end
            end

            S_WRITE: begin
               r_state <= S_IDLE;
               r_we    <= 1'b0;
               r_addr  <= '0;
               r_wdata <= '0;
               r_ready <= '0;
               if (i_req_last[r_grant]) begin
                  r_locked <= 1'b0;
                  r_rr_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
               end else begin
                  r_locked <= 1'b1;
                  r_tcnt   <= '0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_we    <= 1'b0;
               r_re    <= 1'b0;
               r_addr  <= '0;
               r_wdata <= '0;
               r_ready <= '0;
            end
         endcase
      end
   end

   assign o_req_ready       = r_ready;
   assign o_uart_address    = r_addr;
   assign o_uart_write_data = r_wdata;
   assign o_uart_we         = r_we;
   assign o_uart_re         = r_re;
   assign o_grant_id        = r_grant;
   assign o_locked          = r_locked;

endmodule
